// File: rtl/axi_cfg_slave_pkg.sv
// Shared response codes and FSM state types for the AXI4 configuration register slave.
package axi_cfg_slave_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         rd_state_e;

endpackage

// File: rtl/axi_cfg_slave.sv
// AXI4 slave exposing a bank of 32-bit configuration registers; independent write and read
// engines, INCR-style bursts, SLVERR on beats that fall outside the register window.
module axi_cfg_slave
    import axi_cfg_slave_pkg::*;
#(
    parameter int                         AXI_ID_WIDTH    = 6,
    parameter int                         AXIL_ADDR_WIDTH = 40,
    parameter int                         AXIL_WIDTH      = 32,
    parameter int                         AXIL_STRB_WIDTH = 4,
    parameter logic [AXIL_ADDR_WIDTH-1:0] AXIL_BASE_ADDR  = '0,
    parameter int                         N_REG           = 32,
    localparam int                        IW              = $clog2(N_REG)
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [AXI_ID_WIDTH-1:0]       s_axi_awid,
    input  logic [AXIL_ADDR_WIDTH-1:0]    s_axi_awaddr,
    input  logic [7:0]                    s_axi_awlen,
    input  logic [2:0]                    s_axi_awsize,
    input  logic [1:0]                    s_axi_awburst,
    input  logic                          s_axi_awlock,
    input  logic [3:0]                    s_axi_awcache,
    input  logic [2:0]                    s_axi_awprot,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [AXIL_WIDTH-1:0]         s_axi_wdata,
    input  logic [AXIL_STRB_WIDTH-1:0]    s_axi_wstrb,
    input  logic                          s_axi_wlast,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [AXI_ID_WIDTH-1:0]       s_axi_bid,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [AXI_ID_WIDTH-1:0]       s_axi_arid,
    input  logic [AXIL_ADDR_WIDTH-1:0]    s_axi_araddr,
    input  logic [7:0]                    s_axi_arlen,
    input  logic [2:0]                    s_axi_arsize,
    input  logic [1:0]                    s_axi_arburst,
    input  logic                          s_axi_arlock,
    input  logic [3:0]                    s_axi_arcache,
    input  logic [2:0]                    s_axi_arprot,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [AXI_ID_WIDTH-1:0]       s_axi_rid,
    output logic [AXIL_WIDTH-1:0]         s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rlast,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    output logic [N_REG*AXIL_WIDTH-1:0]   cfg_q,
    output logic                          cfg_wen,
    output logic [IW-1:0]                 cfg_widx
);

    localparam int AW = AXIL_ADDR_WIDTH;

    // Word offset from base; MSB flags an address below the base.
    typedef logic [AW:0] woff_t;

    function automatic woff_t decode(input logic [AW-1:0] addr);
        logic [AW:0] diff;
        woff_t       d;
        diff  = {1'b0, addr} - {1'b0, AXIL_BASE_ADDR};
        d     = woff_t'(diff >> 2);
        d[AW] = diff[AW];
        return d;
    endfunction

    function automatic logic in_range(input woff_t d);
        return !d[AW] && (d[AW-1:0] < AW'(N_REG));
    endfunction

    logic [N_REG-1:0][AXIL_WIDTH-1:0] regs;
    logic                             live;
    wr_state_e                        wr_state, wr_next;
    woff_t                            w_off;
    logic [7:0]                       w_len, w_cnt;
    logic                             w_err, w_beat, w_hit, w_last;
    logic [IW-1:0]                    w_idx;
    logic [AXIL_WIDTH-1:0]            w_merged;
    logic                             unused;

    assign unused = ^{s_axi_awsize, s_axi_awburst, s_axi_awlock, s_axi_awcache, s_axi_awprot,
                      s_axi_wlast, s_axi_arsize, s_axi_arburst, s_axi_arlock, s_axi_arcache,
                      s_axi_arprot};

    assign cfg_q         = regs;
    assign s_axi_awready = live && (wr_state == W_IDLE);
    assign s_axi_wready  = (wr_state == W_DATA);
    assign s_axi_bvalid  = (wr_state == W_RESP);

    assign w_beat = (wr_state == W_DATA) && s_axi_wvalid;
    assign w_hit  = w_beat && in_range(w_off);
    assign w_idx  = w_off[IW-1:0];
    assign w_last = (w_cnt == w_len);

    always_comb begin
        w_merged = regs[w_idx];
        for (int k = 0; k < AXIL_STRB_WIDTH; k++)
            if (s_axi_wstrb[k]) w_merged[8*k +: 8] = s_axi_wdata[8*k +: 8];
    end

    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            W_IDLE:  if (s_axi_awvalid && s_axi_awready) wr_next = W_DATA;
            W_DATA:  if (w_beat && w_last)               wr_next = W_RESP;
            W_RESP:  if (s_axi_bready)                   wr_next = W_IDLE;
            default:                                     wr_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            live        <= 1'b0;
            wr_state    <= W_IDLE;
            regs        <= '0;
            cfg_wen     <= 1'b0;
            cfg_widx    <= '0;
            w_off       <= '0;
            w_len       <= '0;
            w_cnt       <= '0;
            w_err       <= 1'b0;
            s_axi_bid   <= '0;
            s_axi_bresp <= AXI_RESP_OKAY;
        end else begin
            live     <= 1'b1;
            wr_state <= wr_next;
            cfg_wen  <= w_hit;
            if (w_hit) begin
                regs[w_idx] <= w_merged;
                cfg_widx    <= w_idx;
            end
            if (s_axi_awvalid && s_axi_awready) begin
                s_axi_bid <= s_axi_awid;
                w_off     <= decode(s_axi_awaddr);
                w_len     <= s_axi_awlen;
                w_cnt     <= '0;
                w_err     <= 1'b0;
            end
            if (w_beat) begin
                w_off <= w_off + woff_t'(1);
                w_cnt <= w_cnt + 8'd1;
                if (!in_range(w_off)) w_err <= 1'b1;
                if (w_last)
                    s_axi_bresp <= (w_err || !in_range(w_off)) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            end
        end
    end

    rd_state_e             rd_state, rd_next;
    woff_t                 r_off, r_load_off;
    logic [7:0]            r_len, r_cnt;
    logic                  ar_hs, r_adv;
    logic [AXIL_WIDTH-1:0] r_src;

    assign s_axi_arready = live && (rd_state == R_IDLE);
    assign s_axi_rvalid  = (rd_state == R_DATA);
    assign s_axi_rlast   = (rd_state == R_DATA) && (r_cnt == r_len);

    assign ar_hs      = s_axi_arvalid && s_axi_arready;
    assign r_adv      = (rd_state == R_DATA) && s_axi_rready && !s_axi_rlast;
    assign r_load_off = ar_hs ? decode(s_axi_araddr) : r_off + woff_t'(1);
    // Forward a write landing on the same edge so the next beat sees the new value.
    assign r_src      = (w_hit && (w_idx == r_load_off[IW-1:0])) ? w_merged : regs[r_load_off[IW-1:0]];

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            R_IDLE:  if (ar_hs)                       rd_next = R_DATA;
            R_DATA:  if (s_axi_rready && s_axi_rlast) rd_next = R_IDLE;
            default:                                  rd_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_state    <= R_IDLE;
            r_off       <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            s_axi_rid   <= '0;
            s_axi_rdata <= '0;
            s_axi_rresp <= AXI_RESP_OKAY;
        end else begin
            rd_state <= rd_next;
            if (ar_hs) begin
                s_axi_rid <= s_axi_arid;
                r_len     <= s_axi_arlen;
                r_cnt     <= '0;
            end
            if (r_adv) r_cnt <= r_cnt + 8'd1;
            if (ar_hs || r_adv) begin
                r_off       <= r_load_off;
                s_axi_rdata <= in_range(r_load_off) ? r_src : '0;
                s_axi_rresp <= in_range(r_load_off) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            end
        end
    end

endmodule
